packet_deframe: RTL
===================

# packet_deframe

Receive-side deframer for the GTX packet link. Consumes the word-aligned 32-bit/4-bit-K stream from the word aligner in the `rx_clk` domain, recognises the SOP/payload/EOP framing that the transmit-side packet generator emits, and forwards payload as a qualified stream with packet type and length. It also checks length, K-character placement and the optional counting payload pattern, and keeps saturating good/error packet counters for ILA and status readout.

## Interface
- `MAX_LEN`, 1024: largest legal payload length in words; SOP with a larger length is an error.
- `CHECK_PATTERN`, 1: when 1, payload word k must equal `{c,c,c,c}` with c = k mod 256.
- `rx_clk` in 1: recovered receive clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `gt_rx_data` in 32: aligned data. Byte 0 is `[7:0]`.
- `gt_rx_ctrl` in 4: per-byte K flag; bit i qualifies byte i.
- `rx_packet_valid` out 1: payload word valid.
- `rx_packet_data` out 32: payload word.
- `rx_packet_sop` out 1: first payload word of the packet.
- `rx_packet_eop` out 1: word number `len` of the packet.
- `rx_packet_type` out 8: type from SOP, held until the next SOP.
- `rx_packet_len` out 16: length from SOP, held until the next SOP.
- `rx_packet_done` out 1: one-cycle pulse for a good packet.
- `rx_packet_err` out 1: one-cycle pulse for a failed or aborted packet.
- `rx_err_code` out 3: cause of the last error, held.
- `packet_cnt_o` out 32: good packets, saturating.
- `error_packet_cnt_o` out 32: errored packets, saturating.

## Operation
Word classes (decoded per cycle; a word is one class only):
- IDLE word: ctrl 4'b0001, byte0 0xBC.
- SOP word: ctrl 4'b0001, byte0 0xFB; byte1 = type; bytes[3:2] = len (words).
- EOP word: ctrl 4'b0001, byte0 0xFD.
- DATA word: ctrl 4'b0000.
- BADK: any other ctrl value, or ctrl 4'b0001 with another byte0.

States:
- S_IDLE
  - SOP with 1 ≤ len ≤ MAX_LEN → latch type and len, clear the word count and pattern flag, go to S_PAYLOAD.
  - SOP with len 0 or len > MAX_LEN → error code 1.
  - All other words are ignored, including a stray EOP or DATA word.
- S_PAYLOAD
  - DATA → emit the word; count++; compare against the pattern.
  - When the count reaches len, go to S_WAIT_EOP.
- S_WAIT_EOP
  - EOP → if the pattern flag is clear, `rx_packet_done`; otherwise error code 5.
  - Then go to S_IDLE.

Error conditions (each pulses `rx_packet_err` and latches `rx_err_code`):
- In S_PAYLOAD:
  - EOP → code 2 (short packet), go to S_IDLE.
  - IDLE or BADK → code 4, go to S_IDLE.
- In S_WAIT_EOP:
  - DATA → code 3 (long packet), go to S_IDLE.
  - IDLE or BADK → code 4, go to S_IDLE.
- SOP in S_PAYLOAD or S_WAIT_EOP → code 6 (truncated) for the old packet. The SOP is then processed as if in S_IDLE, in the same cycle. If that SOP is also invalid, only code 6 is reported.

Error code values: 0 none, 1 bad length, 2 short, 3 long, 4 unexpected K, 5 pattern, 6 truncated.

Other rules:
- A pattern mismatch does not stop forwarding. The mismatch is flagged and reported at EOP instead of `done`.
- Payload of errored packets that was already emitted is not retracted.
- Counters saturate at 0xFFFF_FFFF.
- `packet_cnt_o` increments with `done`; `error_packet_cnt_o` increments with `err`, once per packet.

## Timing
- All outputs are registered.
- A word sampled at rising edge N produces its output at edge N+1:
  - valid/data/sop/eop for payload words;
  - `done`/`err` one cycle after the EOP or offending word;
  - counters in the same cycle as the pulse.
- type and len update one cycle after the SOP, coincident with no valid.
- len = 1: sop and eop are asserted on the same word.
- Back-to-back packets (EOP followed immediately by SOP) are accepted with no gap.
- Reset values: all outputs 0, state S_IDLE.
- Reset mid-packet discards the packet with no error counted.

## Structure
- `packet_pkg` holds:
  - K codes 0xBC/0xFB/0xFD;
  - word-class enum;
  - state enum;
  - error-code localparams.
- The package is shared with the transmit-side generator.
- One sub-module, `sat_cnt32` (async-reset saturating increment counter), is instantiated twice.
- The classifier and FSM are inline.

## Test plan
- Two back-to-back packets, type 8, len 256, correct pattern:
  - 512 valid words with correct sop/eop;
  - two `done` pulses;
  - `packet_cnt_o` = 2;
  - error count 0.
- len 4 packet, EOP after 3 words → after the EOP word:
  - `err`, code 2;
  - the 3 words emitted, none with eop;
  - `error_packet_cnt_o` = 1.
- len 4 packet with the word-2 payload corrupted to 0xDEADBEEF → 4 words emitted, then at EOP+1 `err`, code 5, no `done`.
- SOP (len 8) arriving during word 5 of a len-16 packet:
  - `err`, code 6;
  - new type/len latched;
  - the next 8 words emitted with a fresh sop;
  - then `done`.
- SOP with len 0, then ctrl 4'b0010 inside a packet → code 1, then code 4; the FSM returns to S_IDLE each time.
- Assert `rst` mid-packet, then run a good len-1 packet → counters 0 after reset; sop = eop = 1 on one word; `done`; `packet_cnt_o` = 1.

Source files
------------

// File: rtl/packet_pkg.sv
// packet_pkg
// Shared definitions for the GTX packet link. The transmit-side packet
// generator and the receive-side deframer both import it, so the framing
// K characters, word classes, deframer states and error codes stay consistent
// on both ends of the link.
//   K_IDLE / K_SOP / K_EOP : byte-0 K characters of the control words
//   word_class_e           : classification of one aligned 32-bit word
//   state_e                : deframer states
//   ERR_*                  : values reported on rx_err_code
package packet_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOP  = 8'hFB;
    localparam logic [7:0] K_EOP  = 8'hFD;

    typedef enum logic [2:0] {
        W_IDLE,
        W_SOP,
        W_EOP,
        W_DATA,
        W_BADK
    } word_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_WAIT_EOP
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_LEN = 3'd1;
    localparam logic [2:0] ERR_SHORT   = 3'd2;
    localparam logic [2:0] ERR_LONG    = 3'd3;
    localparam logic [2:0] ERR_UNEXP_K = 3'd4;
    localparam logic [2:0] ERR_PATTERN = 3'd5;
    localparam logic [2:0] ERR_TRUNC   = 3'd6;

endpackage

// File: rtl/packet_deframe_if.sv
// packet_deframe_if
// Bundles the receive stream coming from the word aligner and everything the
// deframer reports back (payload stream, packet status, counters).
//   gt_rx_data/gt_rx_ctrl : aligned word and per-byte K flags (into deframer)
//   rx_packet_*           : qualified payload stream with type/len
//   rx_packet_done/err    : per-packet result pulses, rx_err_code holds cause
//   packet_cnt_o/error_packet_cnt_o : saturating good/error packet counters
// Modports: master = the side feeding words and observing results,
//           slave  = the deframer itself.
interface packet_deframe_if;

    logic [31:0] gt_rx_data;
    logic [3:0]  gt_rx_ctrl;

    logic        rx_packet_valid;
    logic [31:0] rx_packet_data;
    logic        rx_packet_sop;
    logic        rx_packet_eop;
    logic [7:0]  rx_packet_type;
    logic [15:0] rx_packet_len;
    logic        rx_packet_done;
    logic        rx_packet_err;
    logic [2:0]  rx_err_code;
    logic [31:0] packet_cnt_o;
    logic [31:0] error_packet_cnt_o;

    modport master (
        output gt_rx_data, gt_rx_ctrl,
        input  rx_packet_valid, rx_packet_data, rx_packet_sop, rx_packet_eop,
        input  rx_packet_type, rx_packet_len, rx_packet_done, rx_packet_err,
        input  rx_err_code, packet_cnt_o, error_packet_cnt_o
    );

    modport slave (
        input  gt_rx_data, gt_rx_ctrl,
        output rx_packet_valid, rx_packet_data, rx_packet_sop, rx_packet_eop,
        output rx_packet_type, rx_packet_len, rx_packet_done, rx_packet_err,
        output rx_err_code, packet_cnt_o, error_packet_cnt_o
    );

endinterface

// File: rtl/sat_cnt32.sv
// sat_cnt32
// 32-bit event counter that increments by one per cycle while 'inc' is high
// and sticks at 0xFFFF_FFFF instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current (registered) count
module sat_cnt32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/packet_deframe.sv
// packet_deframe
// Receive-side deframer for the GTX packet link. Classifies each aligned word,
// tracks SOP / payload / EOP framing, forwards payload with sop/eop marks and
// the packet type/length, and reports each packet as done or errored
// (length, K placement, optional counting payload pattern).
//   rx_clk : recovered receive clock (only clock)
//   rst    : asynchronous active-high reset
//   bus    : packet_deframe_if.slave, input words plus all results
// Parameters:
//   MAX_LEN       : largest legal payload length in words
//   CHECK_PATTERN : when 1, payload word k must be {c,c,c,c}, c = k mod 256
module packet_deframe
    import packet_pkg::*;
#(
    parameter int MAX_LEN       = 1024,
    parameter bit CHECK_PATTERN = 1'b1
) (
    input  logic             rx_clk,
    input  logic             rst,
    packet_deframe_if.slave  bus
);

    state_e      state;
    word_class_e word_class;

    logic [15:0] word_cnt;
    logic        pattern_err;

    logic        valid_q;
    logic [31:0] data_q;
    logic        sop_q;
    logic        eop_q;
    logic [7:0]  type_q;
    logic [15:0] len_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  err_code_q;

    logic [15:0] sop_len;
    logic        sop_len_ok;
    logic        start_pkt;
    logic        last_word;
    logic        pattern_ok;
    logic        done_evt;
    logic        err_evt;

    // Classify the incoming word and derive this cycle's packet events. The
    // done/err events feed both the pulse registers and the counters so the
    // counters move on the same edge the pulses appear.
    always_comb begin
        word_class = W_BADK;
        if (bus.gt_rx_ctrl == 4'b0000) begin
            word_class = W_DATA;
        end else if (bus.gt_rx_ctrl == 4'b0001) begin
            case (bus.gt_rx_data[7:0])
                K_IDLE:  word_class = W_IDLE;
                K_SOP:   word_class = W_SOP;
                K_EOP:   word_class = W_EOP;
                default: word_class = W_BADK;
            endcase
        end

        sop_len    = bus.gt_rx_data[31:16];
        sop_len_ok = (sop_len != 16'd0) && (sop_len <= 16'(MAX_LEN));
        // A valid SOP starts a new packet from any state; in a busy state the
        // old packet is reported as truncated in the same cycle.
        start_pkt  = (word_class == W_SOP) && sop_len_ok;
        last_word  = ((word_cnt + 16'd1) == len_q);
        pattern_ok = !CHECK_PATTERN || (bus.gt_rx_data == {4{word_cnt[7:0]}});

        done_evt = (state == S_WAIT_EOP) && (word_class == W_EOP) && !pattern_err;

        err_evt = 1'b0;
        case (state)
            S_IDLE:     err_evt = (word_class == W_SOP) && !sop_len_ok;
            S_PAYLOAD:  err_evt = (word_class != W_DATA);
            S_WAIT_EOP: err_evt = !done_evt;
            default:    err_evt = 1'b0;
        endcase
    end

    // Framing FSM with all stream/status outputs registered alongside it.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            word_cnt    <= 16'd0;
            pattern_err <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 32'd0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            type_q      <= 8'd0;
            len_q       <= 16'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= done_evt;
            err_q   <= err_evt;

            if (start_pkt) begin
                type_q      <= bus.gt_rx_data[15:8];
                len_q       <= sop_len;
                word_cnt    <= 16'd0;
                pattern_err <= 1'b0;
                state       <= S_PAYLOAD;
            end

            case (state)
                S_IDLE: begin
                    if ((word_class == W_SOP) && !sop_len_ok) begin
                        err_code_q <= ERR_BAD_LEN;
                    end
                end
                S_PAYLOAD: begin
                    case (word_class)
                        W_DATA: begin
                            valid_q  <= 1'b1;
                            data_q   <= bus.gt_rx_data;
                            sop_q    <= (word_cnt == 16'd0);
                            eop_q    <= last_word;
                            word_cnt <= word_cnt + 16'd1;
                            if (!pattern_ok) begin
                                pattern_err <= 1'b1;
                            end
                            if (last_word) begin
                                state <= S_WAIT_EOP;
                            end
                        end
                        W_EOP: begin
                            err_code_q <= ERR_SHORT;
                            state      <= S_IDLE;
                        end
                        W_SOP: begin
                            err_code_q <= ERR_TRUNC;
                            if (!sop_len_ok) begin
                                state <= S_IDLE;
                            end
                        end
                        default: begin
                            err_code_q <= ERR_UNEXP_K;
                            state      <= S_IDLE;
                        end
                    endcase
                end
                S_WAIT_EOP: begin
                    case (word_class)
                        W_EOP: begin
                            if (pattern_err) begin
                                err_code_q <= ERR_PATTERN;
                            end
                            state <= S_IDLE;
                        end
                        W_DATA: begin
                            err_code_q <= ERR_LONG;
                            state      <= S_IDLE;
                        end
                        W_SOP: begin
                            err_code_q <= ERR_TRUNC;
                            if (!sop_len_ok) begin
                                state <= S_IDLE;
                            end
                        end
                        default: begin
                            err_code_q <= ERR_UNEXP_K;
                            state      <= S_IDLE;
                        end
                    endcase
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sat_cnt32 u_good_cnt (
        .clk   (rx_clk),
        .rst   (rst),
        .inc   (done_evt),
        .count (bus.packet_cnt_o)
    );

    sat_cnt32 u_err_cnt (
        .clk   (rx_clk),
        .rst   (rst),
        .inc   (err_evt),
        .count (bus.error_packet_cnt_o)
    );

    assign bus.rx_packet_valid = valid_q;
    assign bus.rx_packet_data  = data_q;
    assign bus.rx_packet_sop   = sop_q;
    assign bus.rx_packet_eop   = eop_q;
    assign bus.rx_packet_type  = type_q;
    assign bus.rx_packet_len   = len_q;
    assign bus.rx_packet_done  = done_q;
    assign bus.rx_packet_err   = err_q;
    assign bus.rx_err_code     = err_code_q;

endmodule
